// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions for the fetch path: default parameters and
// instruction-queue entry field widths.
package fetch_unit_pkg;

    localparam int          DEF_ADDR_WIDTH = 32;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_DEPTH      = 4;
    localparam int unsigned DEF_RESET_PC   = 32'd0;

    localparam int INSTR_W    = DEF_DATA_WIDTH;
    localparam int PC_W       = DEF_ADDR_WIDTH;
    localparam int PC_PLUS1_W = DEF_ADDR_WIDTH;

    // Queue entry layout is {instr, pc, pc_plus1}.
    function automatic int entry_width(input int data_w, input int addr_w);
        return data_w + addr_w + addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a flush input that empties the queue at the next edge.
// Flush wins over any write or read presented in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_ok_s;
    logic             wr_ok_s;

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rd_ok_s = rd_en && (count_q != CNT_W'(0));
        wr_ok_s = wr_en && ((count_q != CNT_W'(DEPTH)) || rd_ok_s);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
            if (wr_ok_s) begin
                mem_d[tail_q] = wr_data;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (rd_ok_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation against a one-cycle-latency imem, with
// returned words buffered in an instruction queue towards decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PC_W,
    parameter int                    DATA_WIDTH = INSTR_W,
    parameter int                    DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  address_imem,
    input  logic [DATA_WIDTH-1:0]  q_imem,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [ADDR_WIDTH-1:0]  out_pc_plus1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = entry_width(DATA_WIDTH, ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  inflight_q, inflight_d;
    logic                  deq_s;
    logic                  enq_s;
    logic                  issue_s;
    logic [CW:0]           occ_s;
    logic [EW-1:0]         wr_data_s;
    logic [EW-1:0]         rd_data_s;

    assign address_imem = pc_q;
    assign out_valid    = (count != CW'(0));
    assign out_instr    = rd_data_s[EW-1 -: DATA_WIDTH];
    assign out_pc       = rd_data_s[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign out_pc_plus1 = rd_data_s[ADDR_WIDTH-1:0];

    // Issue decision and PC / in-flight next state; redirect overrides all.
    always_comb begin
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        inflight_d = 1'b0;
        deq_s      = out_valid & out_ready;
        enq_s      = inflight_q & ~redirect;
        // Counting the in-flight word as occupied guarantees a slot when it lands.
        occ_s      = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(deq_s);
        issue_s    = ~redirect && (occ_s < (CW+1)'(DEPTH));
        wr_data_s  = {q_imem, ipc_q, ipc_q + ADDR_WIDTH'(1)};
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue_s) begin
            pc_d       = pc_q + ADDR_WIDTH'(1);
            ipc_d      = pc_q;
            inflight_d = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and in-flight tracking registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_iq (
        .clock   (clock),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (enq_s),
        .wr_data (wr_data_s),
        .rd_en   (deq_s),
        .rd_data (rd_data_s),
        .count   (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus1;
    logic [2:0]  count;
    logic [31:0] salt;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_imem (address_imem),
        .q_imem       (q_imem),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus1 (out_pc_plus1),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem: word at address a is a + 100 + salt, one cycle of read latency.
    always @(posedge clock) q_imem <= address_imem + 32'd100 + salt;

    typedef struct {
        bit          rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr;
    } vec_t;
    vec_t vt[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rst, input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [2:0] ecnt,
                       input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_cnt = ecnt; v.e_addr = eaddr;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] epc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (out_valid) begin
                found = 1'b1;
                chk(nm, out_pc, epc);
                chk({nm, "_instr"}, out_instr, epc + 32'd100 + salt);
            end
            adv();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: no out_valid within 10 cycles, expected pc %h", nm, epc);
        end
    endtask

    // Reference: a queue of entries plus a PC and one pending-fetch slot.
    task automatic model_edge();
        bit deq;
        int occ;
        ent_t e;
        deq = (m_q.size() != 0) && out_ready;
        occ = m_q.size() + int'(m_infl) - int'(deq);
        if (redirect) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = redirect_pc;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (m_infl) begin
                e.instr = m_ipc + 32'd100 + salt;
                e.pc    = m_ipc;
                m_q.push_back(e);
            end
            if (occ < 4) begin
                m_infl = 1'b1;
                m_ipc  = m_pc;
                m_pc   = m_pc + 32'd1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("rnd_count", 32'(count), 32'(m_q.size()));
        chk("rnd_addr", address_imem, m_pc);
        if (m_q.size() != 0) begin
            chk("rnd_pc", out_pc, m_q[0].pc);
            chk("rnd_instr", out_instr, m_q[0].instr);
            chk("rnd_pc_plus1", out_pc_plus1, m_q[0].pc + 32'd1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        salt        = 32'h0;

        // Reset release with decode always ready.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1, 2);
        add(0, 1, 0, 0, 1, 1, 1, 3);
        add(0, 1, 0, 0, 1, 2, 1, 4);
        add(0, 1, 0, 0, 1, 3, 1, 5);
        // Decode stalled until the queue fills, then released.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 1, 0, 2, 3);
        add(0, 0, 0, 0, 1, 0, 3, 4);
        add(0, 0, 0, 0, 1, 0, 4, 4);
        add(0, 0, 0, 0, 1, 0, 4, 4);
        add(0, 1, 0, 0, 1, 0, 4, 4);
        add(0, 1, 0, 0, 1, 1, 3, 5);
        add(0, 1, 0, 0, 1, 2, 3, 6);
        add(0, 1, 0, 0, 1, 3, 3, 7);
        add(0, 1, 0, 0, 1, 4, 3, 8);
        // Redirect to 0x40 with three entries queued and one fetch in flight.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 1, 0, 2, 3);
        add(0, 0, 1, 32'h40, 1, 0, 3, 4);
        add(0, 1, 0, 0, 0, 0, 0, 32'h40);
        add(0, 1, 0, 0, 0, 0, 0, 32'h41);
        add(0, 1, 0, 0, 1, 32'h40, 1, 32'h42);
        add(0, 1, 0, 0, 1, 32'h41, 1, 32'h43);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            out_ready   = vt[i].rdy;
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            @(negedge clock);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("tbl%0d_addr", i), address_imem, vt[i].e_addr);
            if (vt[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), out_pc, vt[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), out_instr, vt[i].e_pc + 32'd100);
                chk($sformatf("tbl%0d_pc1", i), out_pc_plus1, vt[i].e_pc + 32'd1);
            end
            adv();
        end
        redirect = 1'b0;

        // Redirect while the head handshake completes: head consumed exactly once.
        out_ready = 1'b1;
        do_reset();
        adv(); adv(); adv();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clock);
        chk("rdq_valid", 32'(out_valid), 32'd1);
        chk("rdq_pc", out_pc, 32'd1);
        adv();
        redirect = 1'b0;
        @(negedge clock);
        chk("rdq_count_after", 32'(count), 32'd0);
        chk("rdq_addr_after", address_imem, 32'h80);
        wait_valid("rdq_first", 32'h80);

        // Back-to-back redirects: only the second target is fetched.
        do_reset();
        adv(); adv(); adv(); adv();
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        adv();
        redirect_pc = 32'h20;
        @(negedge clock);
        chk("b2b_addr1", address_imem, 32'h10);
        adv();
        redirect = 1'b0;
        @(negedge clock);
        chk("b2b_addr2", address_imem, 32'h20);
        chk("b2b_count", 32'(count), 32'd0);
        wait_valid("b2b_first", 32'h20);

        // PC wrap at the top of the address space.
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        adv();
        redirect = 1'b0;
        wait_valid("wrap_first", 32'hFFFF_FFFF);
        @(negedge clock);
        chk("wrap_pc", out_pc, 32'h0);
        adv();

        // Asynchronous reset between edges, mid-stream.
        do_reset();
        for (int k = 0; k < 5; k++) adv();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_addr", address_imem, 32'h0);
        adv();
        chk("areset_hold_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("areset_c0_addr", address_imem, 32'h0);
        adv();
        wait_valid("areset_first", 32'h0);

        // Randomized run against the reference model.
        reset = 1'b1;
        salt  = $urandom;
        #1;
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = 32'h0;
        m_ipc  = 32'h0;
        adv();
        reset = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
                default: redirect_pc = 32'($urandom_range(0, 255));
            endcase
            @(negedge clock);
            model_check();
            @(posedge clock);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
